alu_pipe: RTL



---
 rtl/alu_pipe_if.sv | 31 +++
 rtl/alu_pipe.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle for alu_pipe.
//   slave  (alu_pipe side): takes in_valid/in_a/in_b/in_op/out_ready,
//                           drives in_ready/out_valid/out_r and the flags.
//   master (producer/consumer side): the mirror image.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_r;
  logic             out_zero;
  logic             out_neg;
  logic             out_carry;
  logic             out_ovf;
  logic             out_illegal;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_r, out_zero, out_neg, out_carry, out_ovf, out_illegal
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_r, out_zero, out_neg, out_carry, out_ovf, out_illegal
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked WIDTH-bit ALU (AND/OR/ADD/SUB/SLT/NOR) with a
// registered result and flag set (zero, neg, carry/borrow, ovf, illegal).
// Optional shift-add multiplier (opcode 3) compiled in when the macro
// ALU_PIPE_MUL_EN is defined; otherwise opcode 3 is treated as illegal.
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   alu_pipe_if.slave: in_valid/in_ready/in_a/in_b/in_op,
//         out_valid/out_ready/out_r/out_zero/out_neg/out_carry/out_ovf/out_illegal
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);
  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam int         CW     = $clog2(WIDTH);
  typedef enum logic [0:0] {IDLE, MUL} state_t;
`else
  typedef enum logic [0:0] {IDLE} state_t;
`endif

  state_t state_q, state_d;

  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH:0]   sum, diff;
  logic             slt;
  logic [WIDTH-1:0] res;
  logic             res_carry, res_ovf, res_illegal;

  assign a = bus.in_a;
  assign b = bus.in_b;

  assign bus.in_ready = (state_q == IDLE) && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Extra top bit gives ADD carry-out and SUB borrow (A < B unsigned).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign slt  = $signed(a) < $signed(b);

  always_comb begin
    res         = '0;
    res_carry   = 1'b0;
    res_ovf     = 1'b0;
    res_illegal = 1'b0;
    case (bus.in_op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_NOR: res = ~(a | b);
      OP_ADD: begin
        res       = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
        res_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res       = diff[WIDTH-1:0];
        res_carry = diff[WIDTH];
        res_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: res = {{(WIDTH-1){1'b0}}, slt};
`ifdef ALU_PIPE_MUL_EN
      OP_MUL: res = '0;
`endif
      default: res_illegal = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
  logic [CW-1:0]    cnt;

  assign is_mul   = (bus.in_op == OP_MUL);
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_done = (state_q == MUL) && (cnt == CW'(WIDTH - 1));

  // One multiplier bit per cycle; the WIDTH-th step lands straight in out_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept && is_mul) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state_q == MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
`ifdef ALU_PIPE_MUL_EN
    case (state_q)
      IDLE:    if (accept && is_mul) state_d = MUL;
      MUL:     if (mul_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`endif
  end

  // A MUL accept falls through to the drain branch: in_ready guaranteed the
  // old result is leaving, so out_valid drops for the duration of the multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.out_r       <= '0;
      bus.out_zero    <= 1'b0;
      bus.out_neg     <= 1'b0;
      bus.out_carry   <= 1'b0;
      bus.out_ovf     <= 1'b0;
      bus.out_illegal <= 1'b0;
    end else if (accept && !is_mul) begin
      bus.out_valid   <= 1'b1;
      bus.out_r       <= res;
      bus.out_zero    <= (res == '0);
      bus.out_neg     <= res[WIDTH-1];
      bus.out_carry   <= res_carry;
      bus.out_ovf     <= res_ovf;
      bus.out_illegal <= res_illegal;
`ifdef ALU_PIPE_MUL_EN
    end else if (mul_done) begin
      bus.out_valid   <= 1'b1;
      bus.out_r       <= acc_next;
      bus.out_zero    <= (acc_next == '0);
      bus.out_neg     <= acc_next[WIDTH-1];
      bus.out_carry   <= 1'b0;
      bus.out_ovf     <= 1'b0;
      bus.out_illegal <= 1'b0;
`endif
    end else if (bus.out_ready) begin
      bus.out_valid   <= 1'b0;
    end
  end
endmodule
